image_slot_scheduler: RTL and testbench

Ping-pong slot controller for the resized-crop stage. It writes incoming pixels from the upstream augmentation stream into two fixed BRAM image slots and tracks which slots hold a complete image. It issues `crop_start` to the crop engine strictly in slot order and frees each slot on the engine's `image_done`. It also forwards downstream back-pressure to the engine as `crop_interrupt`.

---
 rtl/image_slot_scheduler_if.sv | 29 ++
 rtl/image_slot_scheduler.sv | 116 +++++++++++
 tb/tb_image_slot_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/image_slot_scheduler_if.sv
// Bundle between the pixel source / crop engine side (master) and the slot scheduler (slave).
interface image_slot_scheduler_if;
    logic [7:0]  in_pixel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bram_wr_addr;
    logic [31:0] bram_wr_data;
    logic        bram_wr_en;
    logic        crop_start;
    logic        crop_image_done;
    logic        crop_interrupt;
    logic        out_ready;
    logic [1:0]  slot_full;
    logic        err_done_unexpected;
    logic [15:0] img_in_count;
    logic [15:0] img_out_count;

    modport master (
        output in_pixel, in_valid, crop_image_done, out_ready,
        input  in_ready, bram_wr_addr, bram_wr_data, bram_wr_en, crop_start,
               crop_interrupt, slot_full, err_done_unexpected, img_in_count, img_out_count
    );

    modport slave (
        input  in_pixel, in_valid, crop_image_done, out_ready,
        output in_ready, bram_wr_addr, bram_wr_data, bram_wr_en, crop_start,
               crop_interrupt, slot_full, err_done_unexpected, img_in_count, img_out_count
    );
endinterface

// File: rtl/image_slot_scheduler.sv
// Ping-pong BRAM slot writer with an in-order crop-engine launcher.
// Define SCHED_STATS_EN to build the image in/out statistics counters.
module image_slot_scheduler #(
    parameter int          NUM_PIXELS = 784,
    parameter logic [31:0] BASE_ADDR1 = 32'hB000_0000,
    parameter logic [31:0] BASE_ADDR2 = 32'hB000_1000
) (
    input logic                   clk,
    input logic                   reset_n,
    image_slot_scheduler_if.slave bus
);
    typedef enum logic [1:0] {R_IDLE, R_START, R_BUSY} rd_state_t;

    rd_state_t   state;
    logic        wr_slot;
    logic        rd_slot;
    logic [9:0]  wr_cnt;
    logic [1:0]  slot_full;
    logic        crop_start_q;
    logic        err_q;
    logic        in_ready_c;
    logic        wr_fire;
    logic        wr_last;
    logic        done_ok;
    logic [1:0]  set_mask;
    logic [1:0]  clr_mask;
    logic [31:0] wr_base;

    assign in_ready_c = !slot_full[wr_slot];
    assign wr_fire    = bus.in_valid && in_ready_c;
    assign wr_last    = (wr_cnt == 10'(NUM_PIXELS - 1));
    assign wr_base    = wr_slot ? BASE_ADDR2 : BASE_ADDR1;
    assign done_ok    = (state == R_BUSY) && bus.crop_image_done;

    // A slot set by the writer and the other slot cleared by the reader can coincide.
    assign set_mask = (wr_fire && wr_last) ? (wr_slot ? 2'b10 : 2'b01) : 2'b00;
    assign clr_mask = done_ok ? (rd_slot ? 2'b10 : 2'b01) : 2'b00;

    assign bus.in_ready            = in_ready_c;
    assign bus.bram_wr_en          = wr_fire;
    assign bus.bram_wr_addr        = wr_fire ? (wr_base + {20'd0, wr_cnt, 2'b00}) : 32'd0;
    assign bus.bram_wr_data        = wr_fire ? {24'd0, bus.in_pixel} : 32'd0;
    assign bus.crop_start          = crop_start_q;
    assign bus.crop_interrupt      = (state == R_BUSY) && !bus.out_ready;
    assign bus.slot_full           = slot_full;
    assign bus.err_done_unexpected = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_slot <= 1'b0;
            wr_cnt  <= 10'd0;
        end else if (wr_fire) begin
            if (wr_last) begin
                wr_cnt  <= 10'd0;
                wr_slot <= !wr_slot;
            end else begin
                wr_cnt <= wr_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) slot_full <= 2'b00;
        else          slot_full <= (slot_full | set_mask) & ~clr_mask;
    end

    // Reader follows the engine's own slot alternation, so rd_slot never skips.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= R_IDLE;
            rd_slot      <= 1'b0;
            crop_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            crop_start_q <= 1'b0;
            if (bus.crop_image_done && (state != R_BUSY)) err_q <= 1'b1;
            case (state)
                R_IDLE: begin
                    if (slot_full[rd_slot]) begin
                        state        <= R_START;
                        crop_start_q <= 1'b1;
                    end
                end
                R_START: state <= R_BUSY;
                R_BUSY: begin
                    if (bus.crop_image_done) begin
                        rd_slot <= !rd_slot;
                        state   <= R_IDLE;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_cnt  <= 16'd0;
            out_cnt <= 16'd0;
        end else begin
            if (set_mask != 2'b00) in_cnt  <= in_cnt + 16'd1;
            if (done_ok)           out_cnt <= out_cnt + 16'd1;
        end
    end

    assign bus.img_in_count  = in_cnt;
    assign bus.img_out_count = out_cnt;
`else
    assign bus.img_in_count  = 16'd0;
    assign bus.img_out_count = 16'd0;
`endif
endmodule

// File: tb/tb_image_slot_scheduler.sv
// Randomized bench for image_slot_scheduler against an image-count based reference model.
`timescale 1ns/1ps
module tb_image_slot_scheduler;
    localparam int          NPIX  = 784;
    localparam logic [31:0] BASE0 = 32'hB000_0000;
    localparam logic [31:0] BASE1 = 32'hB000_1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    image_slot_scheduler_if bus();

    image_slot_scheduler #(
        .NUM_PIXELS(NPIX), .BASE_ADDR1(BASE0), .BASE_ADDR2(BASE1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: images are numbered in arrival order; image k lives in slot k%2.
    int cyc;
    int written;
    int consumed;
    int wcnt;
    int start_cyc;
    int last_done;
    bit started;
    bit m_err;
    int full_time [16];

    task automatic model_reset();
        written = 0; consumed = 0; wcnt = 0; started = 0; m_err = 0;
        start_cyc = 0; last_done = -100;
        for (int k = 0; k < 16; k++) full_time[k] = 0;
    endtask

    function automatic bit start_due();
        int t;
        if (started || written <= consumed) return 1'b0;
        t = full_time[consumed % 16] + 2;
        if (last_done + 2 > t) t = last_done + 2;
        return cyc >= t;
    endfunction

    function automatic logic [15:0] exp_in_count();
`ifdef SCHED_STATS_EN
        return 16'(written);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [15:0] exp_out_count();
`ifdef SCHED_STATS_EN
        return 16'(consumed);
`else
        return 16'd0;
`endif
    endfunction

    // One clock per iteration: drive after posedge, compare at negedge, advance model at posedge.
    task automatic run(input int ncyc, input int vp, input int dp, input bit spur);
        logic [1:0]  ef;
        logic        ein, fire, busy, est, acc, unexp;
        logic [31:0] eaddr;
        for (int i = 0; i < ncyc; i++) begin
            busy = started && (cyc > start_cyc);
            bus.in_valid        = ($urandom_range(0, 99) < vp);
            bus.in_pixel        = 8'($urandom);
            bus.out_ready       = ($urandom_range(0, 99) < 70);
            bus.crop_image_done = ($urandom_range(0, 99) < dp) && (busy || spur);
            @(negedge clk);
            ef = 2'b00;
            for (int j = consumed; j < written; j++) ef[j % 2] = 1'b1;
            ein   = !ef[written % 2];
            fire  = bus.in_valid && ein;
            eaddr = ((written % 2) ? BASE1 : BASE0) + 32'(4 * wcnt);
            est   = start_due();
            acc   = busy && bus.crop_image_done;
            unexp = bus.crop_image_done && !busy;
            check_eq("slot_full", bus.slot_full, ef);
            check_eq("in_ready", bus.in_ready, ein);
            check_eq("bram_wr_en", bus.bram_wr_en, fire);
            if (fire) begin
                check_eq("bram_wr_addr", bus.bram_wr_addr, eaddr);
                check_eq("bram_wr_data", bus.bram_wr_data, {24'd0, bus.in_pixel});
            end
            check_eq("crop_start", bus.crop_start, est);
            check_eq("crop_interrupt", bus.crop_interrupt, busy && !bus.out_ready);
            check_eq("err_done", bus.err_done_unexpected, m_err);
            check_eq("img_in_count", bus.img_in_count, exp_in_count());
            check_eq("img_out_count", bus.img_out_count, exp_out_count());
            @(posedge clk);
            #1;
            if (fire) begin
                wcnt++;
                if (wcnt == NPIX) begin
                    wcnt = 0;
                    full_time[written % 16] = cyc;
                    written++;
                end
            end
            if (est) begin
                started = 1'b1;
                start_cyc = cyc;
            end
            if (acc) begin
                consumed++;
                started = 1'b0;
                last_done = cyc;
            end
            if (unexp) m_err = 1'b1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.crop_image_done = 1'b0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        #2;
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        check_eq("rst_slot_full", bus.slot_full, 2'b00);
        check_eq("rst_wr_en", bus.bram_wr_en, 1'b0);
        check_eq("rst_crop_start", bus.crop_start, 1'b0);
        check_eq("rst_interrupt", bus.crop_interrupt, 1'b0);
        check_eq("rst_err", bus.err_done_unexpected, 1'b0);
        check_eq("rst_in_count", bus.img_in_count, 16'd0);
        check_eq("rst_out_count", bus.img_out_count, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int guard;
        bus.in_pixel = 8'd0;
        bus.in_valid = 1'b0;
        bus.crop_image_done = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Fill both slots with no consumption, writer stalls on image 3.
        run(1700, 100, 0, 0);
        check_eq("two_full_stall", bus.slot_full, 2'b11);
        run(800, 100, 3, 0);
        run(3000, 70, 4, 0);

        // Drain, then pulse done while the reader is idle.
        guard = 0;
        while ((written != consumed || started) && guard < 2000) begin
            run(1, 0, 20, 0);
            guard++;
        end
        check_eq("drain_done", guard < 2000, 1'b1);
        run(1, 0, 100, 1);
        run(10, 0, 0, 0);
        check_eq("err_sticky", bus.err_done_unexpected, 1'b1);
        run(2500, 90, 3, 1);

        // Reset in the middle of an image.
        do_reset();
        guard = 0;
        while (wcnt != 400 && guard < 2000) begin
            run(1, 100, 0, 0);
            guard++;
        end
        check_eq("reach_px400", wcnt, 400);
        do_reset();
        run(900, 100, 5, 0);

        // Two images written, one consumed.
        do_reset();
        run(1600, 100, 0, 0);
        guard = 0;
        while (consumed < 1 && guard < 50) begin
            run(1, 0, 100, 0);
            guard++;
        end
        check_eq("stats_in", bus.img_in_count, exp_in_count());
        check_eq("stats_out", bus.img_out_count, exp_out_count());
`ifdef SCHED_STATS_EN
        check_eq("stats_in_two", bus.img_in_count, 16'd2);
        check_eq("stats_out_one", bus.img_out_count, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
